// File: rtl/pbp_update_gen.sv
// Perceptron predictor update generator.
// Keeps an in-order queue of prediction records issued by the frontend and
// pairs each branch-unit resolution with the oldest record. A match produces
// a registered one-cycle training update for the predictor. A resolution that
// finds no matching head produces an orphan pulse instead.
module pbp_update_gen #(
    parameter int DEPTH      = 8,
    parameter int GHR_LENGTH = 10,
    parameter int OUT_W      = 16,
    parameter int THETA      = 20,
    parameter int VLEN       = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        debug_mode_i,
    input  logic                        pred_valid_i,
    output logic                        pred_ready_o,
    input  logic [VLEN-1:0]             pred_pc_i,
    input  logic                        pred_taken_i,
    input  logic [OUT_W-1:0]            pred_outcome_i,
    input  logic [GHR_LENGTH-1:0]       pred_ghr_i,
    input  logic                        res_valid_i,
    input  logic [VLEN-1:0]             res_pc_i,
    input  logic                        res_taken_i,
    output logic                        upd_valid_o,
    output logic [VLEN-1:0]             upd_pc_o,
    output logic                        upd_taken_o,
    output logic                        upd_mispredict_o,
    output logic                        upd_train_o,
    output logic [GHR_LENGTH-1:0]       upd_ghr_o,
    output logic                        res_orphan_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [OUT_W-1:0] THETA_V   = OUT_W'(THETA);
    localparam logic [OUT_W-1:0] OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};

    logic [VLEN-1:0]       pc_mem      [DEPTH];
    logic                  taken_mem   [DEPTH];
    logic [OUT_W-1:0]      outcome_mem [DEPTH];
    logic [GHR_LENGTH-1:0] ghr_mem     [DEPTH];

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  head_match;
    logic                  resolve;
    logic                  orphan;
    logic                  desync;
    logic [VLEN-1:0]       head_pc;
    logic                  head_taken;
    logic [OUT_W-1:0]      head_outcome;
    logic [GHR_LENGTH-1:0] head_ghr;
    logic [OUT_W-1:0]      head_mag;
    logic                  head_mispredict;
    logic                  head_train;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);

    // Readiness comes only from the registered count; a pop in the same cycle
    // does not make room for a push.
    assign pred_ready_o = !full && !rst_i;
    assign push         = pred_valid_i && pred_ready_o && !flush_i;

    assign head_pc      = pc_mem[rd_ptr_q];
    assign head_taken   = taken_mem[rd_ptr_q];
    assign head_outcome = outcome_mem[rd_ptr_q];
    assign head_ghr     = ghr_mem[rd_ptr_q];

    assign head_match = !empty && (head_pc == res_pc_i);
    assign resolve    = res_valid_i && head_match;
    assign orphan     = res_valid_i && !head_match;
    // A resolution that disagrees with a live head means the queue has lost
    // sync with the branch unit, so everything queued is thrown away.
    assign desync     = res_valid_i && !empty && !head_match;

    assign count_o = count_q;

    // Magnitude of the perceptron sum; the most negative value saturates so
    // it can never fall under the training threshold.
    always_comb begin
        head_mag = head_outcome;
        if (head_outcome[OUT_W-1]) begin
            if (head_outcome == OUT_MIN) begin
                head_mag = OUT_MAX;
            end else begin
                head_mag = -head_outcome;
            end
        end
    end

    assign head_mispredict = head_taken ^ res_taken_i;
    assign head_train      = head_mispredict || (head_mag <= THETA_V);

    // Record storage; contents need no reset because validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]      <= pred_pc_i;
            taken_mem[wr_ptr_q]   <= pred_taken_i;
            outcome_mem[wr_ptr_q] <= pred_outcome_i;
            ghr_mem[wr_ptr_q]     <= pred_ghr_i;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i || desync) begin
            // Any push this cycle is dropped, so the current write pointer
            // marks the new empty position.
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (resolve) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, resolve})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered update and orphan outputs, one cycle after the resolution.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_valid_o      <= 1'b0;
            upd_pc_o         <= '0;
            upd_taken_o      <= 1'b0;
            upd_mispredict_o <= 1'b0;
            upd_train_o      <= 1'b0;
            upd_ghr_o        <= '0;
            res_orphan_o     <= 1'b0;
        end else begin
            upd_valid_o  <= resolve && !debug_mode_i;
            res_orphan_o <= orphan;
            if (resolve) begin
                upd_pc_o         <= head_pc;
                upd_taken_o      <= res_taken_i;
                upd_mispredict_o <= head_mispredict;
                upd_train_o      <= head_train;
                upd_ghr_o        <= head_ghr;
            end
        end
    end

endmodule

// File: tb/tb_pbp_update_gen.sv
// Testbench for pbp_update_gen: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_pbp_update_gen;

    localparam int DEPTH = 8;
    localparam int GHR_L = 10;
    localparam int OUT_W = 16;
    localparam int THETA = 20;
    localparam int VLEN  = 64;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 flush_i;
    logic                 debug_mode_i;
    logic                 pred_valid_i;
    logic                 pred_ready_o;
    logic [VLEN-1:0]      pred_pc_i;
    logic                 pred_taken_i;
    logic [OUT_W-1:0]     pred_outcome_i;
    logic [GHR_L-1:0]     pred_ghr_i;
    logic                 res_valid_i;
    logic [VLEN-1:0]      res_pc_i;
    logic                 res_taken_i;
    logic                 upd_valid_o;
    logic [VLEN-1:0]      upd_pc_o;
    logic                 upd_taken_o;
    logic                 upd_mispredict_o;
    logic                 upd_train_o;
    logic [GHR_L-1:0]     upd_ghr_o;
    logic                 res_orphan_o;
    logic [3:0]           count_o;

    pbp_update_gen #(
        .DEPTH(DEPTH), .GHR_LENGTH(GHR_L), .OUT_W(OUT_W), .THETA(THETA), .VLEN(VLEN)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o), .pred_pc_i(pred_pc_i),
        .pred_taken_i(pred_taken_i), .pred_outcome_i(pred_outcome_i), .pred_ghr_i(pred_ghr_i),
        .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
        .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o), .upd_taken_o(upd_taken_o),
        .upd_mispredict_o(upd_mispredict_o), .upd_train_o(upd_train_o), .upd_ghr_o(upd_ghr_o),
        .res_orphan_o(res_orphan_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [VLEN-1:0]  pc;
        logic             taken;
        logic [OUT_W-1:0] outcome;
        logic [GHR_L-1:0] ghr;
    } rec_t;

    rec_t mq[$];

    int n_chk = 0;
    int n_err = 0;

    logic             e_valid;
    logic             e_orphan;
    logic [VLEN-1:0]  e_pc;
    logic             e_taken;
    logic             e_mis;
    logic             e_train;
    logic [GHR_L-1:0] e_ghr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst_i        = 1'b0;
        flush_i      = 1'b0;
        debug_mode_i = 1'b0;
        pred_valid_i = 1'b0;
        pred_pc_i    = '0;
        pred_taken_i = 1'b0;
        pred_outcome_i = '0;
        pred_ghr_i   = '0;
        res_valid_i  = 1'b0;
        res_pc_i     = '0;
        res_taken_i  = 1'b0;
    endtask

    // Reference model: apply the current inputs to the record queue and work
    // out what the update port must show after the next rising edge.
    task automatic model_step();
        bit   ready;
        bit   push;
        bit   drop;
        rec_t r;
        int   o;
        int   mag;
        ready = !rst_i && (mq.size() < DEPTH);
        e_valid  = 1'b0;
        e_orphan = 1'b0;
        if (rst_i) begin
            mq.delete();
        end else begin
            push = pred_valid_i && ready && !flush_i;
            drop = flush_i;
            if (res_valid_i) begin
                if (mq.size() > 0 && mq[0].pc == res_pc_i) begin
                    r = mq.pop_front();
                    e_valid = !debug_mode_i;
                    e_pc    = r.pc;
                    e_taken = res_taken_i;
                    e_mis   = r.taken != res_taken_i;
                    o   = int'($signed(r.outcome));
                    mag = (o < 0) ? -o : o;
                    if (mag > 32767) mag = 32767;
                    e_train = e_mis || (mag <= THETA);
                    e_ghr   = r.ghr;
                end else begin
                    e_orphan = 1'b1;
                    if (mq.size() > 0) begin
                        mq.delete();
                        drop = 1'b1;
                    end
                end
            end
            if (flush_i) mq.delete();
            if (push && !drop) begin
                r.pc = pred_pc_i; r.taken = pred_taken_i;
                r.outcome = pred_outcome_i; r.ghr = pred_ghr_i;
                mq.push_back(r);
            end
        end
    endtask

    // One clock with the currently driven inputs, then compare at the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        check("count", 64'(count_o), 64'(mq.size()));
        check("ready", 64'(pred_ready_o), 64'(!rst_i && mq.size() < DEPTH));
        check("upd_valid", 64'(upd_valid_o), 64'(e_valid));
        check("orphan", 64'(res_orphan_o), 64'(e_orphan));
        if (e_valid) begin
            check("upd_pc", upd_pc_o, e_pc);
            check("upd_taken", 64'(upd_taken_o), 64'(e_taken));
            check("upd_mis", 64'(upd_mispredict_o), 64'(e_mis));
            check("upd_train", 64'(upd_train_o), 64'(e_train));
            check("upd_ghr", 64'(upd_ghr_o), 64'(e_ghr));
        end
        if (rst_i) begin
            check("rst_upd_pc", upd_pc_o, 64'd0);
            check("rst_upd_ghr", 64'(upd_ghr_o), 64'd0);
        end
    endtask

    task automatic set_push(input logic [63:0] pc, input logic tk,
                            input logic [15:0] oc, input logic [9:0] g);
        pred_valid_i = 1'b1; pred_pc_i = pc; pred_taken_i = tk;
        pred_outcome_i = oc; pred_ghr_i = g;
    endtask

    task automatic set_res(input logic [63:0] pc, input logic tk);
        res_valid_i = 1'b1; res_pc_i = pc; res_taken_i = tk;
    endtask

    task automatic do_push(input logic [63:0] pc, input logic tk,
                           input logic [15:0] oc, input logic [9:0] g);
        idle_inputs(); set_push(pc, tk, oc, g); tick();
    endtask

    task automatic do_res(input logic [63:0] pc, input logic tk);
        idle_inputs(); set_res(pc, tk); tick();
    endtask

    task automatic do_reset();
        idle_inputs(); rst_i = 1'b1; tick(); tick();
        idle_inputs(); tick();
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // 1: basic correct prediction, strong outcome, no training
        do_push(64'h80, 1'b1, 16'sd50, 10'h3A5);
        do_res(64'h80, 1'b1);
        check("t1_train", 64'(upd_train_o), 64'd0);
        check("t1_ghr", 64'(upd_ghr_o), 64'h3A5);

        // 2: mispredict, threshold boundary, saturating most-negative outcome
        do_push(64'h84, 1'b1, -16'sd7, 10'h011);
        do_res(64'h84, 1'b0);
        check("t2_mis", 64'(upd_mispredict_o), 64'd1);
        do_push(64'h88, 1'b0, 16'sd20, 10'h022);
        do_res(64'h88, 1'b0);
        check("t2_theta", 64'(upd_train_o), 64'd1);
        do_push(64'h8C, 1'b0, 16'sd21, 10'h023);
        do_res(64'h8C, 1'b0);
        check("t2_theta1", 64'(upd_train_o), 64'd0);
        do_push(64'h90, 1'b1, 16'h8000, 10'h033);
        do_res(64'h90, 1'b1);
        check("t2_minneg", 64'(upd_train_o), 64'd0);

        // 3: fill, overfill, drain with pointer wrap
        for (int i = 0; i < 9; i++)
            do_push(64'h200 + 64'(4*i), i[0], 16'(i*5), 10'(i));
        check("t3_full_cnt", 64'(count_o), 64'd8);
        check("t3_full_rdy", 64'(pred_ready_o), 64'd0);
        for (int i = 0; i < 8; i++)
            do_res(64'h200 + 64'(4*i), 1'b1);
        check("t3_drain_rdy", 64'(pred_ready_o), 64'd1);

        // 4: orphans on empty queue and on pc mismatch
        do_res(64'h300, 1'b0);
        idle_inputs(); tick();
        do_push(64'h100, 1'b0, 16'sd3, 10'h1);
        do_push(64'h104, 1'b1, 16'sd3, 10'h2);
        do_res(64'h104, 1'b1);
        check("t4_orphan", 64'(res_orphan_o), 64'd1);
        check("t4_cnt", 64'(count_o), 64'd0);
        // empty + push + resolve in one cycle
        idle_inputs(); set_push(64'h400, 1'b1, 16'sd1, 10'h4); set_res(64'h400, 1'b1); tick();

        // 5: resolve with flush, push during flush is dropped
        do_reset();
        for (int i = 0; i < 3; i++) do_push(64'h500 + 64'(4*i), 1'b1, 16'sd100, 10'(i));
        idle_inputs(); set_res(64'h500, 1'b0); flush_i = 1'b1;
        set_push(64'h600, 1'b1, 16'sd1, 10'h6); tick();
        check("t5_cnt", 64'(count_o), 64'd0);

        // 6: debug mode suppression, then reset with a record queued
        do_push(64'h700, 1'b1, 16'sd9, 10'h7);
        do_push(64'h704, 1'b1, 16'sd9, 10'h8);
        idle_inputs(); debug_mode_i = 1'b1; set_res(64'h700, 1'b1); tick();
        check("t6_dbg_cnt", 64'(count_o), 64'd1);
        do_reset();
        check("t6_rst_rdy", 64'(pred_ready_o), 64'd1);

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle_inputs();
            if ($urandom_range(0, 99) < 60) begin
                logic [15:0] oc;
                case ($urandom_range(0, 3))
                    0: oc = 16'($urandom);
                    1: oc = 16'($urandom_range(0, 48)) - 16'd24;
                    2: oc = 16'h8000;
                    default: oc = 16'($urandom_range(0, 200));
                endcase
                set_push(64'({$urandom_range(0, 63), 2'b00}), 1'($urandom), oc, 10'($urandom));
            end
            if ($urandom_range(0, 99) < 45) begin
                if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                    set_res(mq[0].pc, 1'($urandom));
                else
                    set_res(64'({$urandom_range(0, 63), 2'b00}), 1'($urandom));
            end
            flush_i      = ($urandom_range(0, 99) < 2);
            debug_mode_i = ($urandom_range(0, 99) < 15);
            rst_i        = ($urandom_range(0, 199) < 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pbp_update_gen.md
Name: pbp_update_gen

Overview:
- Execute-side producer of perceptron predictor training updates.
- Queues one record per predicted branch issued by the frontend (pc, predicted direction, perceptron outcome, speculative GHR snapshot).
- Matches each record in order against branch-unit resolutions and emits a registered one-cycle update (mispredict, train, committed direction, GHR) back to the predictor.
- Sits between frontend/branch unit and the predictor's update port; the upd_* outputs map onto ariane_pkg::pbp_update_t at the top level.

Parameters:
- DEPTH, 8, in-flight prediction records; power of two, >=2.
- GHR_LENGTH, 10, width of the GHR snapshot.
- OUT_W, 16, width of the signed perceptron outcome.
- THETA, 20, training threshold on |outcome|; 0 <= THETA < 2^(OUT_W-1).

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush; discards all queued records.
- debug_mode_i  in  1  suppresses update emission.
- pred_valid_i  in  1  frontend pushes a prediction record.
- pred_ready_o  out  1  queue can accept a record.
- pred_pc_i  in  riscv::VLEN  branch pc.
- pred_taken_i  in  1  predicted direction.
- pred_outcome_i  in  OUT_W  signed perceptron sum.
- pred_ghr_i  in  GHR_LENGTH  speculative GHR at prediction time.
- res_valid_i  in  1  branch unit resolved the oldest branch.
- res_pc_i  in  riscv::VLEN  resolved branch pc.
- res_taken_i  in  1  actual direction.
- upd_valid_o  out  1  update strobe, one cycle.
- upd_pc_o  out  riscv::VLEN  pc of updated branch.
- upd_taken_o  out  1  actual direction.
- upd_mispredict_o  out  1  predicted != actual.
- upd_train_o  out  1  weights must be trained.
- upd_ghr_o  out  GHR_LENGTH  GHR snapshot for the branch.
- res_orphan_o  out  1  one-cycle pulse: resolution had no matching head.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset:
  - While rst_i is high: count=0, rd/wr pointers=0, and all upd_* and res_orphan_o are 0 on the next edge.
  - pred_ready_o = !full & !rst_i, so it is 1 in the first cycle after rst_i deasserts.
- Push:
  - Push occurs when pred_valid_i & pred_ready_o & !flush_i.
  - A record is written at wr_ptr; wr_ptr wraps modulo DEPTH.
  - pred_ready_o is derived only from the registered count; there is no same-cycle bypass, so at full the queue stays not-ready even if a pop occurs that cycle.
- Resolve:
  - Resolve occurs on res_valid_i with count>0 and head.pc == res_pc_i.
  - Pops the head.
  - Next cycle: upd_valid_o = !debug_mode_i; upd_pc_o = head.pc; upd_taken_o = res_taken_i; upd_mispredict_o = head.taken ^ res_taken_i; upd_ghr_o = head.ghr.
  - upd_train_o = upd_mispredict_o | (|head.outcome| <= THETA).
  - For the |outcome| computation, the most negative value saturates to 2^(OUT_W-1)-1, so it never trains on magnitude.
- Orphan:
  - Trigger: res_valid_i with count==0, or a pc mismatch with the head.
  - Next cycle: res_orphan_o=1 and upd_valid_o=0.
  - A pc mismatch also clears the queue (desync recovery).
  - A push in the same cycle as the orphan is still dropped on mismatch; on the count==0 case it is accepted.
- Empty + push + resolve in the same cycle: the resolution is an orphan (the record is not yet visible); the push is accepted.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- flush_i:
  - A resolve in the same cycle is processed first (its update is still emitted next cycle).
  - The queue is then emptied: count=0, rd_ptr=wr_ptr.
  - A push in the flush cycle is dropped.
- debug_mode_i: records still pop and orphan detection still works; only upd_valid_o is forced to 0.
- Latency: resolve to update is exactly 1 cycle. upd_* are registered and hold their value when upd_valid_o=0 (don't-care).
- Reset mid-operation: queued records are discarded; any update that would have fired next cycle is suppressed.

Test Plan:
1. After reset, push pc=0x80 taken=1 outcome=+50 ghr=0x3A5; resolve pc=0x80 taken=1 -> next cycle upd_valid=1, mispredict=0, train=0, ghr=0x3A5.
2. Push outcome=-7, resolve with the opposite direction -> mispredict=1, train=1. Push outcome=+20 (THETA), resolve correct -> train=1. Push outcome=-(2^15), resolve correct -> train=0.
3. Push 8 records -> pred_ready_o=0, count_o=8. 9th push is ignored. Resolve all 8 in order -> 8 updates with matching pcs; pointers wrap; pred_ready_o=1.
4. Resolve with an empty queue -> res_orphan_o=1 for one cycle, no update. Push pc 0x100/0x104, then resolve pc=0x104 -> orphan pulse, count_o=0.
5. Push 3 records; resolve the head together with flush_i -> one update for the head, count_o=0. A push asserted during the flush cycle does not appear in count_o.
6. Push 2 records; set debug_mode_i=1 and resolve one -> upd_valid stays 0, count_o=1. Assert rst_i with 1 queued -> count_o=0, pred_ready_o=1 after release.
